// File: rtl/seq_priority_encoder.sv
// Serialises a multi-hot request vector into one binary index per beat, in priority order (optional SEQ_ENC_COUNT_EN adds out_count).
// Latency: first beat one cycle after acceptance; max(k,1) beats per vector, back-to-back with no bubble.
// Backpressure: out_ready low holds the current beat and pend; in_ready drops until the last beat retires.
module seq_priority_encoder #(
  parameter int N         = 8,
  parameter int MSB_FIRST = 1,
  localparam int IDX_W    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_zero
`ifdef SEQ_ENC_COUNT_EN
  ,
  output logic [IDX_W:0]   out_count
`endif
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     pend_q, pend_d;
  logic             zero_q, zero_d;
  logic [N-1:0]     sel;
  logic [IDX_W-1:0] idx;
  logic             scan;
  logic             last;
  logic             load;

  assign scan = (state_q == SCAN);
  assign last = ~|(pend_q & (pend_q - N'(1)));

  // Later loop iterations override earlier ones, so iteration order sets the priority.
  always_comb begin
    idx = '0;
    sel = '0;
    if (MSB_FIRST != 0) begin
      for (int i = 0; i < N; i++) begin
        if (pend_q[i]) begin
          idx    = IDX_W'(i);
          sel    = '0;
          sel[i] = 1'b1;
        end
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (pend_q[i]) begin
          idx    = IDX_W'(i);
          sel    = '0;
          sel[i] = 1'b1;
        end
      end
    end
  end

  assign out_valid = scan;
  assign out_idx   = scan ? idx : '0;
  assign out_last  = scan & last;
  assign out_zero  = scan & zero_q;
  assign in_ready  = rst_n & (~scan | (out_ready & last));
  assign load      = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = SCAN;
          pend_d  = din;
          zero_d  = (din == '0);
        end
      end
      SCAN: begin
        if (out_ready) begin
          pend_d = pend_q & ~sel;
          if (last) begin
            if (load) begin
              pend_d = din;
              zero_d = (din == '0);
            end else begin
              state_d = IDLE;
              zero_d  = 1'b0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      zero_q  <= zero_d;
    end
  end

`ifdef SEQ_ENC_COUNT_EN
  logic [IDX_W:0] pop;
  logic [IDX_W:0] count_q;

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + (IDX_W + 1)'(din[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= pop;
    end
  end

  assign out_count = scan ? count_q : '0;
`endif

endmodule

// File: doc/seq_priority_encoder.md
Name: seq_priority_encoder

Overview:
Parametrised, registered successor to the combinational 4-to-2 binary encoder. It accepts an N-bit multi-hot request vector over a valid/ready handshake. It then emits the binary index of every set bit, one index per output beat, in priority order. A zero vector is flagged explicitly and is never aliased to index 0. It sits between request-collection logic and any serial consumer of bit indices, such as an interrupt dispatcher or a grant sequencer.

Parameters:
N, 8, width of the input vector; must be >= 2
MSB_FIRST, 1, 1 = highest set bit emitted first; 0 = lowest set bit emitted first
IDX_W, $clog2(N), derived localparam, width of the index output; not overridable

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  din holds a vector to encode
in_ready  output  1  block can accept a vector this cycle
din  input  N  request vector
out_valid  output  1  out_idx, out_last and out_zero are valid
out_ready  input  1  consumer accepts the current beat
out_idx  output  IDX_W  binary index of the current set bit
out_last  output  1  current beat is the final beat for this vector
out_zero  output  1  accepted vector was all-zero

Behaviour:
- Single clock domain. Reset is synchronous and active-low; all flops are sampled on the rising edge of clk.
- Reset, applied while rst_n is low at a clock edge:
  - state = IDLE, pend = 0, zero_flag = 0.
  - out_valid = 0, out_idx = 0, out_last = 0, out_zero = 0.
  - in_ready is forced 0 while rst_n is low.
- State machine has two states, IDLE and SCAN. Internal pend register is N bits.
- IDLE:
  - in_ready = 1 and out_valid = 0.
  - On in_valid & in_ready: pend <= din, zero_flag <= (din == 0), move to SCAN.
- SCAN:
  - out_valid = 1.
  - out_idx = index of the highest set bit of pend (MSB_FIRST = 1) or of the lowest set bit (MSB_FIRST = 0).
  - out_last = 1 when pend has at most one set bit.
  - out_zero = zero_flag.
- SCAN when out_valid & out_ready:
  - Clear the emitted bit in pend.
  - If out_last = 1, the vector is complete: return to IDLE, or reload (see below).
- Zero vector: exactly one beat with out_idx = 0, out_zero = 1, out_last = 1.
- Latency: first beat is valid in the cycle after acceptance. A vector with k set bits produces max(k,1) beats.
- Throughput: one beat per cycle while out_ready is held high.
- Back-to-back, no bubble:
  - in_ready = IDLE | (SCAN & out_ready & out_last).
  - If in_valid is high in that last-beat cycle, the new vector loads into pend and the block stays in SCAN.
  - This gives a combinational path from out_ready to in_ready. There is no combinational path from din or in_valid to any output.
- Backpressure: while out_valid & !out_ready, out_idx, out_last and out_zero hold stable and pend is unchanged.
- Input handshake: din is ignored unless in_valid & in_ready. in_valid may be held high without effect while in_ready = 0.
- Reset mid-operation: pending bits are discarded. out_valid = 0 in the cycle after the reset edge. No partial beat is ever emitted.
- Width rule: out_idx is zero-extended binary. Bit positions >= N do not exist, so no out-of-range index can be produced.

Optional Feature:
SEQ_ENC_COUNT_EN
- Defined:
  - Adds output port out_count, width IDX_W+1.
  - out_count = popcount of the vector as captured at acceptance.
  - It is constant across all beats of that vector, 0 for a zero vector, and reset value 0.
  - It is held under backpressure exactly like out_idx.
- Not defined: the port is absent and no popcount logic is generated; all other behaviour is identical.

Test Plan:
1. Reset, then din = 8'b0000_0001 with out_ready = 1 -> one beat: out_idx = 0, out_last = 1, out_zero = 0. Next cycle in_ready = 1 and out_valid = 0.
2. MSB_FIRST = 1, din = 8'b1100_0000, out_ready = 1 -> consecutive beats idx 7 (last = 0) then idx 6 (last = 1). With MSB_FIRST = 0 and din = 8'h06 -> idx 1 then idx 2.
3. din = 8'h00 -> single beat: out_zero = 1, out_idx = 0, out_last = 1. With SEQ_ENC_COUNT_EN defined, out_count = 0.
4. din = 8'b0110_0000 with out_ready low for 3 cycles -> idx 6 held stable and in_ready = 0. Release -> idx 6, then idx 5 (last = 1).
5. din = 8'h81, then din = 8'h08 presented with in_valid during the idx 0 last beat -> vector accepted in that cycle, idx 3 on the next cycle, no idle bubble. With SEQ_ENC_COUNT_EN, out_count = 2 then 1.
6. din = 8'hFF, rst_n pulled low after 2 beats (idx 7, idx 6) -> out_valid = 0 on the next cycle. After release in_ready = 1, and a new din = 8'h10 yields idx 4 only.
